seq_div_unit: RTL

SEQ_DIV_UNIT -- requirements
Module: seq_div_unit

---
 rtl/seq_div_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_div_unit.sv
// seq_div_unit: 32-bit sequential restoring divider (signed or unsigned).
// One quotient bit is resolved per clock, so a result is ready 32 edges after acceptance.
// Result layout is {remainder, quotient}.
// Optional feature: define SEQ_DIV_ZERO_DETECT_EN to short-cut a zero divisor through DIVZERO.
// With it, the result is 0 one edge after acceptance.
// Without it, a zero divisor runs the normal 32 steps.
module seq_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

`ifdef SEQ_DIV_ZERO_DETECT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DIVZERO, ST_ON, ST_END} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_END} state_t;
`endif

    state_t      state_q;
    logic [5:0]  cnt_q;
    // {partial remainder [64:33], next dividend bit / quotient bits [32:0]}
    logic [64:0] shreg_q;
    logic [31:0] divisor_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic [63:0] result_q;
    logic        ready_q;

    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;
    logic        sub_ok;
    logic [31:0] sub_diff;
    logic [64:0] step_d;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes; negating 0x80000000 wraps back to itself, which is the wanted magnitude.
    always_comb begin
        dividend_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        divisor_mag  = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // One restoring step: subtract the divisor from the upper 33 bits when it fits, then shift.
    // The compare is done on the full 33-bit window.
    // When it succeeds, the difference always fits in 32 bits.
    always_comb begin
        sub_ok   = (shreg_q[64:32] >= {1'b0, divisor_q});
        sub_diff = shreg_q[63:32] - divisor_q;
        if (sub_ok) begin
            step_d = {sub_diff, shreg_q[31:0], 1'b1};
        end else begin
            step_d = {shreg_q[63:0], 1'b0};
        end
        quot_fix = neg_quot_q ? (~step_d[31:0] + 32'd1) : step_d[31:0];
        rem_fix  = neg_rem_q ? (~step_d[64:33] + 32'd1) : step_d[64:33];
    end

    // Control FSM and datapath registers; the result and ready are registered.
    // This keeps result_o at zero outside END.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            shreg_q    <= 65'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i && !annul_i) begin
                        shreg_q    <= {32'd0, dividend_mag, 1'b0};
                        divisor_q  <= divisor_mag;
                        neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_q  <= signed_div_i && opdata1_i[31];
                        cnt_q      <= 6'd0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
                        state_q    <= (opdata2_i == 32'd0) ? ST_DIVZERO : ST_ON;
`else
                        state_q    <= ST_ON;
`endif
                    end
                end
`ifdef SEQ_DIV_ZERO_DETECT_EN
                ST_DIVZERO: begin
                    if (annul_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q  <= ST_END;
                        result_q <= 64'd0;
                        ready_q  <= 1'b1;
                    end
                end
`endif
                ST_ON: begin
                    if (annul_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        shreg_q <= step_d;
                        cnt_q   <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            state_q  <= ST_END;
                            result_q <= {rem_fix, quot_fix};
                            ready_q  <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    if (!start_i) begin
                        state_q  <= ST_IDLE;
                        result_q <= 64'd0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    result_q <= 64'd0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
